str_up_sample: RTL and testbench

- Streaming interpolator: the sample-rate-increasing counterpart of the team's framed down-sampler.
- Accepts a framed AXI-stream of signed samples, where tlast marks every LAST-th sample, and emits RATE output beats per input sample.
- Output beats are either zero-stuffed or sample-and-hold, selected by MODE.
- Checks input frame length and re-frames the output so tlast lands on the final beat of the final sample.
- Sits on the DAC/playback side of the LPDAQ subsystem, ahead of the interpolation FIR.

---
 rtl/str_sample_pkg.sv | 27 ++
 rtl/str_frame_checker.sv | 57 +++++
 rtl/str_up_sample.sv | 116 +++++++++++
 tb/tb_str_up_sample.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/str_sample_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : str_sample_pkg                                              |
// | Purpose  : Shared definitions for the framed sample-stream blocks      |
// |            (up-sampler, down-sampler, frame checker).                  |
// | Contents : DEFAULT_DW  - default sample width                          |
// |            width_of()  - clog2-based counter width, minimum 1          |
// |            state_t     - emitter state enum {IDLE, EMIT}               |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package str_sample_pkg;

  localparam int DEFAULT_DW = 24;

  // Width needed to count 0..n-1; never narrower than one bit so that
  // degenerate counts (n = 1 or 2) still give a legal vector.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/str_frame_checker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : str_frame_checker                                           |
// | Purpose  : Tracks the position of accepted samples inside a frame of   |
// |            LAST samples and flags frames whose tlast is early or       |
// |            missing.                                                    |
// | Ports    : clk, rst          - clock, synchronous active-high reset    |
// |            accept            - an input sample is transferred now      |
// |            last              - tlast of that sample                    |
// |            frame_err         - one-cycle pulse, cycle after a bad accept|
// |            frame_err_sticky  - latched error, cleared only by rst      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module str_frame_checker
  import str_sample_pkg::*;
#(
  parameter int LAST = 16000
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic last,
  output logic frame_err,
  output logic frame_err_sticky
);

  localparam int             CW      = width_of(LAST);
  localparam logic [CW-1:0]  CNT_END = CW'(LAST - 1);

  logic [CW-1:0] in_cnt;
  logic          at_end;
  logic          bad;

  assign at_end = (in_cnt == CNT_END);
  // A frame is well formed exactly when tlast coincides with the final slot;
  // any disagreement is either an early end or a missing end.
  assign bad    = last ^ at_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt           <= '0;
      frame_err        <= 1'b0;
      frame_err_sticky <= 1'b0;
    end else begin
      frame_err <= accept & bad;
      if (accept & bad) begin
        frame_err_sticky <= 1'b1;
      end
      // Restart on the sender's tlast so the count resynchronises to it.
      if (accept) begin
        in_cnt <= (last | at_end) ? '0 : in_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/str_up_sample.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : str_up_sample                                               |
// | Purpose  : Streaming interpolator. Each accepted input sample becomes  |
// |            RATE output beats, either zero-stuffed (MODE 0) or held     |
// |            (MODE 1). Output tlast sits on the final beat of a sample   |
// |            that arrived with tlast. Input framing is checked.          |
// | Ports    : clk, rst                      - clock, sync active-high rst |
// |            s_axis_tdata/tlast/tvalid/tready - input stream             |
// |            m_axis_tdata/tlast/tvalid/tready - output stream            |
// |            frame_err, frame_err_sticky   - input framing errors        |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module str_up_sample
  import str_sample_pkg::*;
#(
  parameter int DW   = DEFAULT_DW,
  parameter int RATE = 4,
  parameter int LAST = 16000,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tlast,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tlast,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          frame_err,
  output logic          frame_err_sticky
);

  generate
    if (RATE < 1 || RATE > 256) begin : g_bad_rate
      $error("str_up_sample: RATE must be in 1..256");
    end
    if (LAST < 2) begin : g_bad_last
      $error("str_up_sample: LAST must be >= 2");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
      $error("str_up_sample: MODE must be 0 or 1");
    end
  endgenerate

  localparam int             PW        = width_of(RATE);
  localparam logic [PW-1:0]  PH_FINAL  = PW'(RATE - 1);
  // Phase whose acceptance moves onto the final beat; unused when RATE=1.
  localparam logic [PW-1:0]  PH_PENULT = PW'((RATE >= 2) ? RATE - 2 : 0);
  localparam bit             HOLD_MODE = (MODE == 1);
  localparam bit             PASS_LAST = (RATE == 1);

  state_t        state;
  logic [DW-1:0] hold;
  logic          hold_last;
  logic [PW-1:0] phase;

  logic final_beat;
  logic in_fire;
  logic out_fire;

  assign final_beat = (state == EMIT) && (phase == PH_FINAL);
  // Ready may depend on m_axis_tready so a new sample can be taken in the
  // same cycle the last beat leaves, keeping the output bus fully busy.
  assign s_axis_tready = (state == IDLE) || (final_beat && m_axis_tready);
  assign in_fire  = s_axis_tvalid && s_axis_tready;
  assign out_fire = m_axis_tvalid && m_axis_tready;

  // Output beat registers are updated one beat ahead of time, so the bus
  // always reflects the current phase and is naturally stable under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      hold          <= '0;
      hold_last     <= 1'b0;
      phase         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (in_fire) begin
      state         <= EMIT;
      hold          <= s_axis_tdata;
      hold_last     <= s_axis_tlast;
      phase         <= '0;
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tlast  <= s_axis_tlast && PASS_LAST;
    end else if (out_fire) begin
      if (final_beat) begin
        state         <= IDLE;
        m_axis_tvalid <= 1'b0;
        m_axis_tdata  <= '0;
        m_axis_tlast  <= 1'b0;
      end else begin
        phase         <= phase + 1'b1;
        m_axis_tdata  <= HOLD_MODE ? hold : '0;
        m_axis_tlast  <= hold_last && (phase == PH_PENULT);
      end
    end
  end

  str_frame_checker #(
    .LAST (LAST)
  ) u_frame_checker (
    .clk              (clk),
    .rst              (rst),
    .accept           (in_fire),
    .last             (s_axis_tlast),
    .frame_err        (frame_err),
    .frame_err_sticky (frame_err_sticky)
  );

endmodule
`default_nettype wire

// File: tb/tb_str_up_sample.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_str_up_sample                                            |
// | Purpose  : Self-checking bench for str_up_sample. Three instances:     |
// |            0: RATE 4 zero-stuff, 1: RATE 4 hold, 2: RATE 1; LAST = 4.  |
// |            A queue model of expected beats is checked every cycle.     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_str_up_sample;

  localparam int DW    = 24;
  localparam int LASTN = 4;
  localparam int ND    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_data  [ND];
  logic          s_last  [ND];
  logic          s_valid [ND];
  logic          s_ready [ND];
  logic [DW-1:0] m_data  [ND];
  logic          m_last  [ND];
  logic          m_valid [ND];
  logic          m_ready [ND];
  logic          ferr    [ND];
  logic          fsticky [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int R = (g == 2) ? 1 : 4;
    localparam int M = (g == 1) ? 1 : 0;
    str_up_sample #(
      .DW(DW), .RATE(R), .LAST(LASTN), .MODE(M)
    ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .s_axis_tdata     (s_data[g]),
      .s_axis_tlast     (s_last[g]),
      .s_axis_tvalid    (s_valid[g]),
      .s_axis_tready    (s_ready[g]),
      .m_axis_tdata     (m_data[g]),
      .m_axis_tlast     (m_last[g]),
      .m_axis_tvalid    (m_valid[g]),
      .m_axis_tready    (m_ready[g]),
      .frame_err        (ferr[g]),
      .frame_err_sticky (fsticky[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Items are {last, data}.
  logic [DW:0] in_q  [ND][$];
  logic [DW:0] exp_q [ND][$];
  logic [DW:0] cap_q [ND][$];
  logic        mr_q  [ND][$];

  int   cnt      [ND];
  int   ferr_cnt [ND];
  logic err_nxt  [ND];
  logic stk      [ND];
  logic post_rst [ND];
  logic acc      [ND];
  logic cap_en   [ND];
  int   vprob = 100;
  int   rprob = 100;

  function automatic int rate_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic bit mode_of(input int i);
    return (i == 1);
  endfunction

  function automatic logic [DW:0] mk(input int d, input bit l);
    logic [DW-1:0] t;
    t = d;
    return {l, t};
  endfunction

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s dut%0d: actual=%0h required=%0h @%0t", nm, i, act, req, $time);
    end
  endtask

  // Compare process: sampled on the falling edge, then the model advances
  // as if the following rising edge had happened.
  always @(negedge clk) begin
    for (int i = 0; i < ND; i++) begin
      logic ev, er, macc, sacc, bad;
      logic [DW-1:0] zd;
      if (rst) begin
        exp_q[i].delete();
        cnt[i]      = 0;
        err_nxt[i]  = 1'b0;
        stk[i]      = 1'b0;
        post_rst[i] = 1'b1;
      end else begin
        ev = (exp_q[i].size() != 0);
        er = !ev || (exp_q[i].size() == 1 && m_ready[i]);
        chk("m_tvalid", i, m_valid[i], ev);
        chk("s_tready", i, s_ready[i], er);
        chk("frame_err", i, ferr[i], err_nxt[i]);
        chk("frame_err_sticky", i, fsticky[i], stk[i]);
        if (post_rst[i]) begin
          chk("rst_m_tdata", i, m_data[i], 0);
          chk("rst_m_tlast", i, m_last[i], 0);
          post_rst[i] = 1'b0;
        end
        if (ev) begin
          chk("m_tdata", i, m_data[i], exp_q[i][0][DW-1:0]);
          chk("m_tlast", i, m_last[i], exp_q[i][0][DW]);
        end
        if (ferr[i]) ferr_cnt[i]++;
        macc = ev && m_ready[i];
        sacc = s_valid[i] && er;
        if (macc) begin
          if (cap_en[i]) cap_q[i].push_back({m_last[i], m_data[i]});
          void'(exp_q[i].pop_front());
        end
        err_nxt[i] = 1'b0;
        if (sacc) begin
          for (int k = 0; k < rate_of(i); k++) begin
            zd = (k == 0 || mode_of(i)) ? s_data[i] : '0;
            exp_q[i].push_back({s_last[i] && (k == rate_of(i) - 1), zd});
          end
          bad        = (s_last[i] != (cnt[i] == LASTN - 1));
          err_nxt[i] = bad;
          if (bad) stk[i] = 1'b1;
          cnt[i] = (s_last[i] || cnt[i] == LASTN - 1) ? 0 : cnt[i] + 1;
          void'(in_q[i].pop_front());
          acc[i] = 1'b1;
        end
      end
    end
  end

  // Driver: valid is held until the beat is accepted.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < ND; i++) begin
      if (!(s_valid[i] && !acc[i])) begin
        acc[i] = 1'b0;
        if (in_q[i].size() != 0 && $urandom_range(1, 100) <= vprob) begin
          s_valid[i] = 1'b1;
          s_data[i]  = in_q[i][0][DW-1:0];
          s_last[i]  = in_q[i][0][DW];
        end else begin
          s_valid[i] = 1'b0;
          s_data[i]  = DW'($urandom);
          s_last[i]  = 1'($urandom);
        end
      end
      if (mr_q[i].size() != 0) m_ready[i] = mr_q[i].pop_front();
      else                     m_ready[i] = ($urandom_range(1, 100) <= rprob);
    end
  end

  task automatic drain(input int maxc);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < maxc && !idle; k++) begin
      @(posedge clk); #1;
      idle = 1'b1;
      for (int i = 0; i < ND; i++)
        if (in_q[i].size() != 0 || exp_q[i].size() != 0 || s_valid[i]) idle = 1'b0;
    end
    chk("drain_timeout", 0, idle, 1);
  endtask

  int            zs [16] = '{5, 0, 0, 0, -3, 0, 0, 0, 7, 0, 0, 0, 9, 0, 0, 0};
  logic [DW-1:0] tv;
  bit            found;
  int            pos;
  bit            lst;

  initial begin
    for (int i = 0; i < ND; i++) begin
      s_valid[i] = 0; s_data[i] = '0; s_last[i] = 0; m_ready[i] = 0;
      acc[i] = 0; cap_en[i] = 0; ferr_cnt[i] = 0; cnt[i] = 0;
      err_nxt[i] = 0; stk[i] = 0; post_rst[i] = 1;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_m_tvalid", 0, m_valid[0], 0);
    chk("reset_s_tready", 0, s_ready[0], 1);

    // Zero-stuff on dut0, hold with 1,0,0,1 backpressure on dut1.
    for (int i = 0; i < ND; i++) cap_en[i] = 1'b1;
    in_q[0].push_back(mk(5, 0));  in_q[0].push_back(mk(-3, 0));
    in_q[0].push_back(mk(7, 0));  in_q[0].push_back(mk(9, 1));
    in_q[1].push_back(mk(-8388608, 0)); in_q[1].push_back(mk(1, 0));
    in_q[1].push_back(mk(2, 0));        in_q[1].push_back(mk(3, 1));
    for (int r = 0; r < 8; r++) begin
      mr_q[1].push_back(1); mr_q[1].push_back(0);
      mr_q[1].push_back(0); mr_q[1].push_back(1);
    end
    drain(500);
    chk("zs_beats", 0, cap_q[0].size(), 16);
    for (int k = 0; k < 16; k++) begin
      tv = zs[k];
      chk("zs_data", 0, cap_q[0][k][DW-1:0], tv);
      chk("zs_last", 0, cap_q[0][k][DW], (k == 15));
    end
    chk("zs_frame_err", 0, ferr_cnt[0], 0);
    for (int k = 0; k < 4; k++) chk("hold_data", 1, cap_q[1][k][DW-1:0], 24'h800000);
    for (int i = 0; i < ND; i++) cap_en[i] = 1'b0;

    // Frame errors on dut0: early end, clean frame, missing end, clean frame.
    ferr_cnt[0] = 0;
    in_q[0].push_back(mk(10, 0)); in_q[0].push_back(mk(11, 0)); in_q[0].push_back(mk(12, 1));
    for (int k = 0; k < 4; k++) in_q[0].push_back(mk(20 + k, k == 3));
    for (int k = 0; k < 4; k++) in_q[0].push_back(mk(30 + k, 0));
    for (int k = 0; k < 4; k++) in_q[0].push_back(mk(40 + k, k == 3));
    drain(1000);
    chk("ferr_pulses", 0, ferr_cnt[0], 2);
    chk("ferr_sticky_set", 0, fsticky[0], 1);

    // Reset while dut0 is at phase 2.
    in_q[0].push_back(mk(60, 0));
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk); #1;
      if (exp_q[0].size() == 2) found = 1'b1;
    end
    chk("reach_phase2", 0, found, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_m_tvalid", 0, m_valid[0], 0);
    chk("midrst_s_tready", 0, s_ready[0], 1);
    chk("midrst_sticky", 0, fsticky[0], 0);
    for (int k = 0; k < 4; k++) in_q[0].push_back(mk(70 + k, k == 3));
    drain(500);

    // Random traffic on all instances with occasional framing faults.
    vprob = 70;
    rprob = 65;
    for (int i = 0; i < ND; i++) begin
      pos = 0;
      for (int n = 0; n < 150; n++) begin
        lst = (pos == LASTN - 1);
        if ($urandom_range(0, 19) == 0) lst = !lst;
        in_q[i].push_back(mk(int'($urandom), lst));
        pos = (lst || pos == LASTN - 1) ? 0 : pos + 1;
      end
    end
    drain(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
